// File: rtl/key_event_fifo.sv
// Debounces scanner key vectors and queues each new press as a 4-bit code in a FWFT FIFO.
// A push lands on the edge of the qualifying scan. out_ready pops the head the same cycle. Presses arriving while full are dropped and flagged.

module key_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [W-1:0]               wr_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // When full, a simultaneous pop frees the slot that the push then reuses.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module key_event_fifo #(
  parameter int DEPTH    = 8,
  parameter int DEBOUNCE = 2
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [15:0]                key,
  input  logic                       scan_valid,
  output logic [3:0]                 out_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clr_overflow
);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic [15:0] sample;
  logic [15:0] sample_nxt;
  logic [15:0] stable;
  logic [15:0] stable_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [15:0] new_keys;
  logic [3:0]  new_code;
  logic        push;
  logic        empty;
  logic        drop;

  always_comb begin
    sample_nxt = sample;
    stable_nxt = stable;
    cnt_nxt    = cnt;
    if (scan_valid) begin
      if (key != sample) begin
        sample_nxt = key;
        cnt_nxt    = 4'd1;
        if (DEBOUNCE == 1) stable_nxt = key;
      end else if (cnt < DB) begin
        cnt_nxt = cnt + 4'd1;
        if (cnt + 4'd1 == DB) stable_nxt = sample;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sample <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sample <= sample_nxt;
      stable <= stable_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Only 0->1 transitions of the debounced vector count; the lowest one wins.
  assign new_keys = stable_nxt & ~stable;
  assign push     = (new_keys != '0);

  always_comb begin
    new_code = '0;
    for (int i = 15; i >= 0; i--) begin
      if (new_keys[i]) new_code = 4'(i);
    end
  end

  key_fifo #(.W(4), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push    (push),
    .wr_data (new_code),
    .pop     (out_ready),
    .rd_data (out_code),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .drop    (drop)
  );

  assign out_valid = !empty;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end
endmodule
